// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD scheduler: FSM state encoding and default width.
package gcd_pkg;

    localparam int GCD_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOADA = 3'd1,
        ST_LOADB = 3'd2,
        ST_RUN   = 3'd3,
        ST_RESP  = 3'd4
    } gcd_state_e;

endpackage

// File: rtl/gcd_rr_arb.sv
// NREQ-way round-robin arbiter: grants the first valid index at or after i_ptr,
// wrapping around. Purely combinational; the caller owns the pointer register.
module gcd_rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    logic [IDW-1:0] w_j;

    // Scan from the pointer position; the first valid requester wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = IDW'((int'(i_ptr) + k) % NREQ);
            if (!o_any && i_valid[w_j]) begin
                o_any        = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = w_j;
            end
        end
    end

endmodule

// File: rtl/gcd_sched_ctrl.sv
// Sequencer and round-robin scheduler for one shared subtractive GCD datapath.
// Valid/ready: a requester holds req_valid until it sees its one-cycle req_ready
// pulse (operands are captured on that cycle); the result is held on rsp_* with
// rsp_valid high until a cycle in which rsp_ready is also high.
module gcd_sched_ctrl
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_gcd,
    output logic [WIDTH-1:0]      rsp_iters,
    output logic                  dp_lda,
    output logic                  dp_ldb,
    output logic                  dp_sel1,
    output logic                  dp_sel2,
    output logic                  dp_sel_in,
    output logic [WIDTH-1:0]      dp_data_in,
    input  logic                  dp_gt,
    input  logic                  dp_lt,
    input  logic                  dp_eq,
    input  logic [WIDTH-1:0]      dp_aout
);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_LOADA = ST_LOADA;
    localparam logic [2:0] S_LOADB = ST_LOADB;
    localparam logic [2:0] S_RUN   = ST_RUN;
    localparam logic [2:0] S_RESP  = ST_RESP;

    logic [2:0]       r_state;
    logic [IDW-1:0]   r_ptr;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IDW-1:0]   r_id;
    logic [WIDTH-1:0] r_gcd;
    logic [WIDTH-1:0] r_iters;

    logic [NREQ-1:0]  w_grant;
    logic [IDW-1:0]   w_idx;
    logic             w_any;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;

    gcd_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .i_valid (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Operand slice belonging to the requester that wins this cycle.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_a = req_a[i*WIDTH +: WIDTH];
                w_sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // FSM, capture registers, pointer and iteration counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_id    <= '0;
            r_gcd   <= '0;
            r_iters <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_id    <= w_idx;
                        r_ptr   <= (w_idx == IDW'(NREQ-1)) ? '0 : w_idx + IDW'(1);
                        r_state <= S_LOADA;
                    end
                end
                S_LOADA: r_state <= S_LOADB;
                S_LOADB: begin
                    r_iters <= '0;
                    // A zero operand would never reach equality by subtraction.
                    if (r_a == '0 || r_b == '0) begin
                        r_gcd   <= r_a | r_b;
                        r_state <= S_RESP;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (dp_eq) begin
                        r_gcd   <= dp_aout;
                        r_state <= S_RESP;
                    end else if (dp_lt || dp_gt) begin
                        if (r_iters != '1) r_iters <= r_iters + WIDTH'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes decoded from the registered state (plus comparator flags in RUN).
    always_comb begin
        req_ready  = '0;
        dp_lda     = 1'b0;
        dp_ldb     = 1'b0;
        dp_sel1    = 1'b0;
        dp_sel2    = 1'b0;
        dp_sel_in  = 1'b0;
        dp_data_in = '0;
        case (r_state)
            S_IDLE: begin
                // Held low during reset so every output is quiet at once.
                if (rst_n) req_ready = w_grant;
            end
            S_LOADA: begin
                dp_data_in = r_a;
                dp_sel_in  = 1'b1;
                dp_lda     = 1'b1;
            end
            S_LOADB: begin
                dp_data_in = r_b;
                dp_sel_in  = 1'b1;
                dp_ldb     = 1'b1;
            end
            S_RUN: begin
                // Priority eq > lt > gt; equality ends the loop with no load.
                if (!dp_eq) begin
                    if (dp_lt) begin
                        dp_sel1 = 1'b1;
                        dp_ldb  = 1'b1;
                    end else if (dp_gt) begin
                        dp_sel2 = 1'b1;
                        dp_lda  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign rsp_valid = (r_state == S_RESP);
    assign rsp_id    = r_id;
    assign rsp_gcd   = r_gcd;
    assign rsp_iters = r_iters;

endmodule

// File: tb/tb_gcd_sched_ctrl.sv
// Testbench for gcd_sched_ctrl paired with a behavioural subtractive GCD datapath.
module tb_gcd_sched_ctrl;

    localparam int WIDTH = 16;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_gcd;
    logic [WIDTH-1:0]      rsp_iters;
    logic                  dp_lda, dp_ldb, dp_sel1, dp_sel2, dp_sel_in;
    logic [WIDTH-1:0]      dp_data_in;
    logic                  dp_gt, dp_lt, dp_eq;
    logic [WIDTH-1:0]      dp_aout;

    logic [WIDTH-1:0] op_a [NREQ];
    logic [WIDTH-1:0] op_b [NREQ];

    int n_checks = 0;
    int n_pass   = 0;
    int m_ptr    = 0;

    gcd_sched_ctrl #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_gcd    (rsp_gcd),
        .rsp_iters  (rsp_iters),
        .dp_lda     (dp_lda),
        .dp_ldb     (dp_ldb),
        .dp_sel1    (dp_sel1),
        .dp_sel2    (dp_sel2),
        .dp_sel_in  (dp_sel_in),
        .dp_data_in (dp_data_in),
        .dp_gt      (dp_gt),
        .dp_lt      (dp_lt),
        .dp_eq      (dp_eq),
        .dp_aout    (dp_aout)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack per-requester operands onto the flat buses.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = op_a[i];
            req_b[i*WIDTH +: WIDTH] = op_b[i];
        end
    end

    // ---------------- GCD datapath (environment) ----------------
    logic [WIDTH-1:0] dpa = '0;
    logic [WIDTH-1:0] dpb = '0;
    logic [WIDTH-1:0] dp_sub;
    assign dp_sub  = (dp_sel1 ? dpb : dpa) - (dp_sel2 ? dpb : dpa);
    assign dp_gt   = dpa > dpb;
    assign dp_lt   = dpa < dpb;
    assign dp_eq   = dpa == dpb;
    assign dp_aout = dpa;
    always @(posedge clk) begin
        if (dp_lda) dpa <= dp_sel_in ? dp_data_in : dp_sub;
        if (dp_ldb) dpb <= dp_sel_in ? dp_data_in : dp_sub;
    end

    // ---------------- reference model ----------------
    // Round-robin choice: first valid index at or after the pointer.
    function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // gcd via Euclid's division; subtractive steps = sum of quotients - 1
    // (the final quotient's last subtraction is replaced by the equality stop).
    function automatic void ref_gcd(input int a, input int b, output int g, output int it);
        int x, y, r;
        if (a == 0 || b == 0) begin
            g  = a | b;
            it = 0;
        end else begin
            x  = a;
            y  = b;
            it = 0;
            while (y != 0) begin
                it += x / y;
                r   = x % y;
                x   = y;
                y   = r;
            end
            g  = x;
            it = it - 1;
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
    endtask

    // Serve one job from the currently raised requests and check everything
    // about it. hold = cycles to keep rsp_ready low once the result appears.
    task automatic do_job(input int hold, input string tag);
        int cyc, eg, e_g, e_it, e_lat, lat, subs, both, stray, bad;
        logic [IDW-1:0]   s_id;
        logic [WIDTH-1:0] s_gcd, s_it;
        #1;
        cyc = 0;
        while (req_ready == '0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        eg = pick(req_valid, m_ptr);
        n_checks++;
        if (eg < 0 || req_ready !== NREQ'(1 << eg)) begin
            $display("FAIL %s grant: got %b want index %0d", tag, req_ready, eg);
            return;
        end else n_pass++;
        ref_gcd(int'(op_a[eg]), int'(op_b[eg]), e_g, e_it);
        e_lat = (op_a[eg] == 0 || op_b[eg] == 0) ? 3 : e_it + 4;
        m_ptr = (eg + 1) % NREQ;
        @(negedge clk);
        req_valid[eg] = 1'b0;
        lat = 1; subs = 0; both = 0; stray = 0;
        while (!rsp_valid && lat < 70000) begin
            if (dp_lda && dp_ldb) both++;
            if ((dp_lda || dp_ldb) && !dp_sel_in) subs++;
            if (req_ready != '0) stray++;
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat !== e_lat) $display("FAIL %s latency: got %0d want %0d", tag, lat, e_lat);
        else n_pass++;
        n_checks++;
        if (rsp_gcd !== WIDTH'(e_g)) $display("FAIL %s gcd: got %0d want %0d", tag, rsp_gcd, e_g);
        else n_pass++;
        n_checks++;
        if (rsp_iters !== WIDTH'(e_it)) $display("FAIL %s iters: got %0d want %0d", tag, rsp_iters, e_it);
        else n_pass++;
        n_checks++;
        if (rsp_id !== IDW'(eg)) $display("FAIL %s id: got %0d want %0d", tag, rsp_id, eg);
        else n_pass++;
        n_checks++;
        if (subs !== e_it || both !== 0 || stray !== 0)
            $display("FAIL %s strobes: subs %0d both %0d grants %0d want subs %0d both 0 grants 0",
                     tag, subs, both, stray, e_it);
        else n_pass++;
        if (hold > 0) begin
            s_id = rsp_id; s_gcd = rsp_gcd; s_it = rsp_iters; bad = 0;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (rsp_valid !== 1'b1 || rsp_id !== s_id || rsp_gcd !== s_gcd ||
                    rsp_iters !== s_it || req_ready !== '0) bad++;
            end
            n_checks++;
            if (bad !== 0) $display("FAIL %s backpressure: got %0d unstable cycles want 0", tag, bad);
            else n_pass++;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0) $display("FAIL %s rsp_drop: got %b want 0", tag, rsp_valid);
        else n_pass++;
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) begin op_a[i] = 16'd5; op_b[i] = 16'd3; end
        @(negedge clk);
        n_checks++;
        if (req_ready !== '0 || rsp_valid !== 1'b0)
            $display("FAIL reset handshake: got ready %b valid %b want 0 0", req_ready, rsp_valid);
        else n_pass++;
        n_checks++;
        if ({dp_lda, dp_ldb, dp_sel1, dp_sel2, dp_sel_in, dp_data_in} !== '0)
            $display("FAIL reset dp: got %b want 0", {dp_lda, dp_ldb, dp_sel1, dp_sel2, dp_sel_in, dp_data_in});
        else n_pass++;
        n_checks++;
        if ({rsp_id, rsp_gcd, rsp_iters} !== '0)
            $display("FAIL reset rsp_fields: got %h want 0", {rsp_id, rsp_gcd, rsp_iters});
        else n_pass++;
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== '0 || dp_lda !== 1'b0 || rsp_valid !== 1'b0)
            $display("FAIL idle_quiet: got ready %b lda %b valid %b want 0", req_ready, dp_lda, rsp_valid);
        else n_pass++;
    endtask

    task automatic test_single();
        op_a[0] = 16'd143; op_b[0] = 16'd78;
        req_valid[0] = 1'b1;
        do_job(0, "single");
    endtask

    task automatic test_rr();
        apply_reset();
        op_a[0] = 16'd48; op_b[0] = 16'd18;
        op_a[2] = 16'd48; op_b[2] = 16'd18;
        req_valid = 4'b0101;
        do_job(0, "rr_first");
        do_job(0, "rr_second");
        op_a[1] = 16'd21; op_b[1] = 16'd14;
        op_a[3] = 16'd9;  op_b[3] = 16'd27;
        req_valid = 4'b1010;
        do_job(0, "rr_wrap");
        do_job(0, "rr_last");
    endtask

    task automatic test_zero();
        op_a[1] = 16'd0; op_b[1] = 16'd35;
        req_valid[1] = 1'b1;
        do_job(0, "zero_a");
        op_a[1] = 16'd0; op_b[1] = 16'd0;
        req_valid[1] = 1'b1;
        do_job(0, "zero_both");
    endtask

    task automatic test_backpressure();
        op_a[0] = 16'd100; op_b[0] = 16'd75;
        op_a[1] = 16'd12;  op_b[1] = 16'd8;
        req_valid[0] = 1'b1;
        req_valid[1] = 1'b1;
        do_job(20, "bp_held");
        do_job(0, "bp_next");
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        apply_reset();
        op_a[0] = 16'hFFFF; op_b[0] = 16'd1;
        req_valid[0] = 1'b1;
        cyc = 0;
        #1;
        while (req_ready == '0 && cyc < 50) begin @(negedge clk); cyc++; end
        @(negedge clk);
        req_valid[0] = 1'b0;
        repeat (20) @(negedge clk);
        op_a[2] = 16'd91; op_b[2] = 16'd35;
        req_valid[2] = 1'b1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_id, rsp_gcd, rsp_iters,
             dp_lda, dp_ldb, dp_sel1, dp_sel2, dp_sel_in, dp_data_in} !== '0)
            $display("FAIL midrun_reset outputs: got %h want 0",
                     {req_ready, rsp_valid, rsp_id, rsp_gcd, rsp_iters,
                      dp_lda, dp_ldb, dp_sel1, dp_sel2, dp_sel_in, dp_data_in});
        else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        do_job(0, "after_reset");
    endtask

    task automatic test_long();
        op_a[3] = 16'hFFFF; op_b[3] = 16'd1;
        req_valid[3] = 1'b1;
        do_job(0, "long");
    endtask

    task automatic test_random();
        logic [NREQ-1:0] mask;
        for (int n = 0; n < 16; n++) begin
            if (req_valid == '0) begin
                mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
                for (int i = 0; i < NREQ; i++) begin
                    if (mask[i]) begin
                        op_a[i] = WIDTH'($urandom_range(0, 400));
                        op_b[i] = WIDTH'($urandom_range(1, 400));
                    end
                end
                req_valid = mask;
            end
            do_job($urandom_range(0, 3), "random");
        end
        for (int n = 0; n < NREQ && req_valid != '0; n++) do_job(0, "drain");
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        req_valid = '0;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin op_a[i] = '0; op_b[i] = '0; end
        test_reset();
        test_single();
        test_rr();
        test_zero();
        test_backpressure();
        test_reset_mid_run();
        test_long();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
